// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// Each iteration shifts {bcd, bin} right by one bit, then subtracts 3 from
// every BCD digit that reads 8 or more. OUT_W iterations produce the result.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [OUT_W-1:0]      o_bin,
    output logic                  o_err
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + OUT_W;
    localparam int CW = $clog2(OUT_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // The largest decimal input must fit in the binary result.
    if (!((64'd1 << OUT_W) > (pow10(DIGITS) - 64'd1))) begin : g_width_check
        $error("bcd_to_bin: OUT_W too small for DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  sr;
    logic [SW-1:0]  sr_step;
    logic [CW-1:0]  cnt;
    logic           bad_digit;
    logic           last_iter;

    // Flag any input digit outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i_bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One reverse double-dabble iteration: shift right, then correct digits >= 8.
    always_comb begin
        sr_step = sr >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_step[OUT_W + 4*i +: 4] >= 4'd8)
                sr_step[OUT_W + 4*i +: 4] = sr_step[OUT_W + 4*i +: 4] - 4'd3;
        end
    end

    assign last_iter = (cnt == CW'(OUT_W - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) state_nxt = bad_digit ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, iteration counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            o_bin <= '0;
            o_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        cnt <= '0;
                        if (bad_digit) begin
                            o_bin <= '0;
                            o_err <= 1'b1;
                        end else begin
                            sr <= {i_bcd, {OUT_W{1'b0}}};
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_step;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        o_bin <= sr_step[OUT_W-1:0];
                        o_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
